// File: rtl/serial_operand_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_operand_tx
// Purpose  : Parallel-to-serial operand transmitter. Accepts an operand pair
//            plus a bit length over a valid/ready handshake and emits the
//            pair LSB-first as a vld/a/b/last stream for the bit-serial
//            adder. A one-entry pending buffer lets operations stream
//            back-to-back; the downstream enable inserts gaps.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            up_vld/up_rdy- upstream handshake
//            up_a, up_b   - parallel operands (WIDTH bits)
//            up_len       - bits to send; 0 or >WIDTH means WIDTH
//            en           - downstream enable; no bit emitted when low
//            vld, a, b    - serial bit valid and operand bits
//            last         - final bit of an operation (only with vld)
//            busy         - shifter active or pending entry held
// Revision : 1.0 - initial release
// ============================================================================
module serial_operand_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [LEN_W-1:0] up_len,
  input  logic             en,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] pa, pb;
  logic [LEN_W-1:0] plen;
  logic             pend;

  logic             xfer;
  logic [LEN_W-1:0] eff_len;
  logic             emit;
  logic             load_in;
  logic             load_pend;
  logic             store_pend;

  // up_rdy is gated by rst so it reads 0 throughout reset.
  assign up_rdy  = rst && !pend;
  assign xfer    = up_vld && up_rdy;
  assign eff_len = (up_len == '0 || up_len > LEN_MAX) ? LEN_MAX : up_len;
  assign busy    = (state == SHIFT) || pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Decide per edge whether a bit goes out and where an accepted pair lands.
  // The shifter counts as free on the edge its last bit leaves, so a pending
  // entry (or, with no pending entry, a fresh transfer) follows with no bubble.
  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          load_in   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (en && cnt == LEN_ONE) begin
          emit = 1'b1;
          if (pend)      load_pend = 1'b1;
          else if (xfer) load_in   = 1'b1;
          else           state_nxt = IDLE;
        end else begin
          emit       = en;
          store_pend = xfer;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa   <= '0;
      sb   <= '0;
      cnt  <= '0;
      pa   <= '0;
      pb   <= '0;
      plen <= '0;
      pend <= 1'b0;
      vld  <= 1'b0;
      a    <= 1'b0;
      b    <= 1'b0;
      last <= 1'b0;
    end else begin
      vld  <= emit;
      a    <= emit & sa[0];
      b    <= emit & sb[0];
      last <= emit && (cnt == LEN_ONE);

      if (load_in) begin
        sa  <= up_a;
        sb  <= up_b;
        cnt <= eff_len;
      end else if (load_pend) begin
        sa   <= pa;
        sb   <= pb;
        cnt  <= plen;
        pend <= 1'b0;
      end else if (emit) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        cnt <= cnt - LEN_ONE;
      end

      if (store_pend) begin
        pa   <= up_a;
        pb   <= up_b;
        plen <= eff_len;
        pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_operand_tx
// Purpose  : Self-checking bench for serial_operand_tx (WIDTH=8). Directed
//            vectors from a table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_operand_tx;

  logic       clk;
  logic       rst;
  logic       up_vld;
  logic       up_rdy;
  logic [7:0] up_a;
  logic [7:0] up_b;
  logic [3:0] up_len;
  logic       en;
  logic       vld;
  logic       a;
  logic       b;
  logic       last;
  logic       busy;

  serial_operand_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy),
    .up_a(up_a), .up_b(up_b), .up_len(up_len), .en(en),
    .vld(vld), .a(a), .b(b), .last(last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [3:0] len;
    int         gap_after;
    int         gap_n;
    int         n;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] esum;
  } vec_t;

  typedef struct {
    logic ba;
    logic bb;
    logic bl;
    int   zeros;
  } beat_t;

  beat_t       beats[$];
  logic [15:0] oa[$];
  logic [15:0] ob[$];
  int          on[$];
  int          zeros;
  bit          xfer_seen;
  int          proto_bad;
  int          total;
  int          bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock: note whether a transfer happens on the coming edge, then
  // sample the outputs at the following falling edge.
  task automatic tick();
    xfer_seen = up_vld && up_rdy;
    @(negedge clk);
    if (last && !vld) proto_bad++;
    if (vld) begin
      beats.push_back('{ba: a, bb: b, bl: last, zeros: zeros});
      zeros = 0;
    end else begin
      zeros++;
    end
  endtask

  function automatic int n_last();
    int c = 0;
    foreach (beats[i]) if (beats[i].bl) c++;
    return c;
  endfunction

  function automatic int inner_zeros(input int skip);
    int c = 0;
    for (int i = 1; i < beats.size(); i++) if (i != skip) c += beats[i].zeros;
    return c;
  endfunction

  // Bit-serial adder model: sum of the first n bits, carry out dropped.
  function automatic logic [15:0] ser_sum(input logic [15:0] x, input logic [15:0] y, input int n);
    logic [15:0] s = '0;
    logic        c = 1'b0;
    for (int i = 0; i < n; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  task automatic split();
    logic [15:0] wa = '0;
    logic [15:0] wb = '0;
    int          k  = 0;
    oa.delete(); ob.delete(); on.delete();
    foreach (beats[i]) begin
      wa[k] = beats[i].ba;
      wb[k] = beats[i].bb;
      k++;
      if (beats[i].bl || k == 16) begin
        oa.push_back(wa); ob.push_back(wb); on.push_back(k);
        wa = '0; wb = '0; k = 0;
      end
    end
  endtask

  task automatic chk_op(input string nm, input int i, input logic [7:0] ea, input logic [7:0] eb, input int n);
    if (oa.size() > i) begin
      chk({nm, "_a"}, oa[i], {8'h0, ea});
      chk({nm, "_b"}, ob[i], {8'h0, eb});
      chk({nm, "_len"}, on[i], n);
    end else begin
      chk({nm, "_missing"}, oa.size(), i + 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  gaps = 0;
    int  n    = 0;
    bit  done = 0;
    string p  = $sformatf("v%0d", idx);
    beats.delete(); zeros = 0;
    up_a = v.va; up_b = v.vb; up_len = v.len; up_vld = 1'b1; en = 1'b1;
    do begin tick(); n++; end while (!xfer_seen && n < 20);
    up_vld = 1'b0;
    if (!xfer_seen) chk({p, "_accept_timeout"}, 0, 1);
    n = 0;
    while (!done && n < 60) begin
      if (beats.size() == v.gap_after && gaps < v.gap_n) begin
        en = 1'b0; gaps++;
      end else begin
        en = 1'b1;
      end
      tick(); n++;
      done = (beats.size() > 0) && beats[$].bl;
    end
    en = 1'b1;
    if (!done) chk({p, "_last_timeout"}, 0, 1);
    chk({p, "_beats"}, beats.size(), v.n);
    chk({p, "_lasts"}, n_last(), 1);
    split();
    chk_op(p, 0, v.ea, v.eb, v.n);
    if (oa.size() > 0) chk({p, "_sum"}, ser_sum(oa[0], ob[0], on[0]), {8'h0, v.esum});
    if (v.gap_n > 0 && beats.size() > v.gap_after)
      chk({p, "_gap"}, beats[v.gap_after].zeros, v.gap_n);
    chk({p, "_other_gaps"}, inner_zeros(v.gap_n > 0 ? v.gap_after : -1), 0);
    chk({p, "_busy_after"}, busy, 0);
  endtask

  vec_t tbl[7];

  initial begin
    total = 0; bad = 0; proto_bad = 0; zeros = 0;
    rst = 1'b1; up_vld = 1'b0; up_a = '0; up_b = '0; up_len = '0; en = 1'b1;

    tbl[0] = '{8'h35, 8'h0F, 4'd8,  0, 0, 8, 8'h35, 8'h0F, 8'h44};
    tbl[1] = '{8'h35, 8'h0F, 4'd8,  2, 3, 8, 8'h35, 8'h0F, 8'h44};
    tbl[2] = '{8'h01, 8'h01, 4'd1,  0, 0, 1, 8'h01, 8'h01, 8'h00};
    tbl[3] = '{8'h35, 8'h0F, 4'd0,  0, 0, 8, 8'h35, 8'h0F, 8'h44};
    tbl[4] = '{8'hA5, 8'h5A, 4'd4,  0, 0, 4, 8'h05, 8'h0A, 8'h0F};
    tbl[5] = '{8'hC3, 8'h3C, 4'd12, 0, 0, 8, 8'hC3, 8'h3C, 8'hFF};
    tbl[6] = '{8'hFF, 8'h01, 4'd3,  1, 2, 3, 8'h07, 8'h01, 8'h00};

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_vld", vld, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_up_rdy", up_rdy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_up_rdy", up_rdy, 1);

    // Reset mid-stream with a pending pair
    begin
      int n = 0;
      int fed = 0;
      beats.delete(); zeros = 0;
      up_a = 8'h35; up_b = 8'h0F; up_len = 4'd8; up_vld = 1'b1;
      while (beats.size() < 3 && n < 40) begin
        tick(); n++;
        if (xfer_seen) begin
          fed++;
          if (fed == 1) begin up_a = 8'hC3; up_b = 8'h3C; end
          else up_vld = 1'b0;
        end
      end
      up_vld = 1'b0;
      chk("mid_reach_beat3", beats.size(), 3);
      chk("mid_pend_full", up_rdy, 0);
      chk("mid_busy_pre", busy, 1);
      chk("mid_vld_pre", vld, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_vld", vld, 0);
      chk("mid_rst_a", a, 0);
      chk("mid_rst_b", b, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      beats.delete();
      for (int i = 0; i < 12; i++) tick();
      chk("mid_after_beats", beats.size(), 0);
      chk("mid_after_up_rdy", up_rdy, 1);
      chk("mid_after_busy", busy, 0);
    end

    // Table-driven vectors
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Back-to-back operations
    begin
      int n = 0;
      int fed = 0;
      int rdy_bad = 0;
      bit seen8 = 0;
      beats.delete(); zeros = 0;
      up_a = 8'h01; up_b = 8'hFF; up_len = 4'd8; up_vld = 1'b1; en = 1'b1;
      while (n_last() < 2 && n < 80) begin
        tick(); n++;
        if (xfer_seen) begin
          fed++;
          if (fed == 1) begin up_a = 8'hA5; up_b = 8'h5A; up_len = 4'd4; end
          else up_vld = 1'b0;
        end
        if (fed == 2 && beats.size() < 8 && up_rdy) rdy_bad++;
        if (beats.size() == 8 && !seen8) begin
          seen8 = 1;
          chk("b2b_rdy_back", up_rdy, 1);
        end
      end
      up_vld = 1'b0;
      chk("b2b_fed", fed, 2);
      chk("b2b_rdy_low_while_pend", rdy_bad, 0);
      chk("b2b_beats", beats.size(), 12);
      chk("b2b_contiguous", inner_zeros(-1), 0);
      if (beats.size() == 12) begin
        chk("b2b_last8", beats[7].bl, 1);
        chk("b2b_last12", beats[11].bl, 1);
      end
      chk("b2b_lasts", n_last(), 2);
      split();
      chk_op("b2b_op0", 0, 8'h01, 8'hFF, 8);
      chk_op("b2b_op1", 1, 8'h05, 8'h0A, 4);
    end

    // Full flow control: up_a changes every cycle while pending is full
    begin
      int n = 0;
      int fed = 0;
      logic [7:0] exp3 = '0;
      bit got3 = 0;
      beats.delete(); zeros = 0;
      up_a = 8'h35; up_b = 8'h0F; up_len = 4'd8; up_vld = 1'b1; en = 1'b1;
      while (fed < 2 && n < 20) begin
        tick(); n++;
        if (xfer_seen) begin
          fed++;
          if (fed == 1) begin up_a = 8'hC3; up_b = 8'h3C; end
        end
      end
      up_b = 8'h06;
      for (int i = 0; i < 30 && !got3; i++) begin
        if (up_rdy) begin
          exp3 = up_a;
          tick();
          got3 = xfer_seen;
          up_vld = 1'b0;
        end else begin
          up_a = 8'(8'h10 + i * 8'h13);
          tick();
        end
      end
      up_vld = 1'b0;
      chk("fc_third_accepted", got3, 1);
      n = 0;
      while (n_last() < 3 && n < 60) begin tick(); n++; end
      chk("fc_beats", beats.size(), 24);
      chk("fc_contiguous", inner_zeros(-1), 0);
      split();
      chk_op("fc_op0", 0, 8'h35, 8'h0F, 8);
      chk_op("fc_op1", 1, 8'hC3, 8'h3C, 8);
      chk_op("fc_op2", 2, exp3, 8'h06, 8);
      chk("fc_busy_after", busy, 0);
    end

    chk("last_without_vld", proto_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
